// File: rtl/fifoctrl_mch.sv
`default_nettype none
// ============================================================================
// Module      : fifoctrl_mch
// Description : Multi-channel FIFO pointer/occupancy controller. NCH logical
//               FIFOs of DEPTH = 1<<ADDRBIT entries each share one external
//               dual-port memory of NCH*DEPTH words addressed {channel, ptr}.
//               Produces the shared write/read strobes and addresses plus
//               per-channel full / not-empty / length / almost flags, with
//               a per-channel flush.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: FIFOCTRL_MCH_ERRFLAG_EN
//   When defined, adds err_clr_i and sticky per-channel overflow/underflow
//   flags err_ovf_o / err_udf_o (registered, one cycle after the request).
//   When undefined, rejected requests are dropped silently.
// ----------------------------------------------------------------------------
// Ports
//   clk            clock, all state on rising edge
//   rst            synchronous reset, active-high
//   fifowr_i       write request
//   wrch_i         write channel
//   fiford_i       read request
//   rdch_i         read channel
//   flush_i        per-channel flush (one bit per channel)
//   afull_thr_i    almost-full threshold (len >= thr), shared
//   aempty_thr_i   almost-empty threshold (len <= thr), shared
//   fifofull_o     per-channel full
//   notempty_o     per-channel not empty
//   almostfull_o   per-channel almost full
//   almostempty_o  per-channel almost empty
//   fifolen_o      channel c length at [c*(ADDRBIT+1) +: ADDRBIT+1]
//   write_o        memory write enable
//   wraddr_o       memory write address {wrch_i, wrcnt[wrch_i]}
//   read_o         memory read enable
//   rdaddr_o       memory read address {rdch_i, rdcnt[rdch_i]}
// ============================================================================
module fifoctrl_mch #(
  parameter int ADDRBIT = 4,
  parameter int NCH     = 4,
  parameter int CHBIT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifowr_i,
  input  logic [CHBIT-1:0]             wrch_i,
  input  logic                         fiford_i,
  input  logic [CHBIT-1:0]             rdch_i,
  input  logic [NCH-1:0]               flush_i,
  input  logic [ADDRBIT:0]             afull_thr_i,
  input  logic [ADDRBIT:0]             aempty_thr_i,
`ifdef FIFOCTRL_MCH_ERRFLAG_EN
  input  logic                         err_clr_i,
  output logic [NCH-1:0]               err_ovf_o,
  output logic [NCH-1:0]               err_udf_o,
`endif
  output logic [NCH-1:0]               fifofull_o,
  output logic [NCH-1:0]               notempty_o,
  output logic [NCH-1:0]               almostfull_o,
  output logic [NCH-1:0]               almostempty_o,
  output logic [NCH*(ADDRBIT+1)-1:0]   fifolen_o,
  output logic                         write_o,
  output logic [CHBIT+ADDRBIT-1:0]     wraddr_o,
  output logic                         read_o,
  output logic [CHBIT+ADDRBIT-1:0]     rdaddr_o
);

  // One-hot channel selects. A channel index >= NCH matches no bit, which
  // both suppresses the strobe and forces the pointer field of the address
  // to zero through the OR-style muxes below.
  logic [NCH-1:0]          w_wr_sel;
  logic [NCH-1:0]          w_rd_sel;
  logic [NCH-1:0]          w_full;
  logic [NCH-1:0]          w_nempty;
  logic [NCH*ADDRBIT-1:0]  w_wrcnt_all;
  logic [NCH*ADDRBIT-1:0]  w_rdcnt_all;
  logic [ADDRBIT-1:0]      w_wrptr;
  logic [ADDRBIT-1:0]      w_rdptr;
  logic                    w_write;
  logic                    w_read;

  // --------------------------------------------------------------------------
  // Shared strobes and address muxes (combinational, valid in request cycle)
  // --------------------------------------------------------------------------
  always_comb begin
    w_wrptr = '0;
    w_rdptr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_wr_sel[c]) w_wrptr = w_wrcnt_all[c*ADDRBIT +: ADDRBIT];
      if (w_rd_sel[c]) w_rdptr = w_rdcnt_all[c*ADDRBIT +: ADDRBIT];
    end
  end

  // No bypass: a read is judged against the pre-write occupancy, a write
  // against the pre-read occupancy.
  assign w_write  = fifowr_i & (|(w_wr_sel & ~w_full   & ~flush_i));
  assign w_read   = fiford_i & (|(w_rd_sel & w_nempty  & ~flush_i));

  assign write_o  = w_write;
  assign read_o   = w_read;
  assign wraddr_o = {wrch_i, w_wrptr};
  assign rdaddr_o = {rdch_i, w_rdptr};

  assign fifofull_o = w_full;
  assign notempty_o = w_nempty;

  // --------------------------------------------------------------------------
  // Per-channel state: write pointer and occupancy. The read pointer is
  // derived (wrcnt - len), so a flush only needs to clear len.
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [ADDRBIT-1:0] wrcnt_q;
    logic [ADDRBIT-1:0] wrcnt_d;
    logic [ADDRBIT:0]   len_q;
    logic [ADDRBIT:0]   len_d;
    logic               w_wr_acc;
    logic               w_rd_acc;

    assign w_wr_sel[c] = (wrch_i == CHBIT'(c));
    assign w_rd_sel[c] = (rdch_i == CHBIT'(c));

    assign w_wr_acc = w_write & w_wr_sel[c];
    assign w_rd_acc = w_read  & w_rd_sel[c];

    assign w_full[c]   = len_q[ADDRBIT];
    assign w_nempty[c] = |len_q;

    assign w_wrcnt_all[c*ADDRBIT +: ADDRBIT] = wrcnt_q;
    assign w_rdcnt_all[c*ADDRBIT +: ADDRBIT] = wrcnt_q - len_q[ADDRBIT-1:0];

    assign fifolen_o[c*(ADDRBIT+1) +: ADDRBIT+1] = len_q;

    // Unsigned compares; a threshold above DEPTH can never be reached for
    // almost-full, and one at/above DEPTH always satisfies almost-empty.
    assign almostfull_o[c]  = (len_q >= afull_thr_i);
    assign almostempty_o[c] = (len_q <= aempty_thr_i);

    always_comb begin
      wrcnt_d = wrcnt_q;
      len_d   = len_q;
      if (flush_i[c]) begin
        // Strobes are already masked for a flushed channel, so the write
        // pointer holds and the read pointer collapses onto it.
        len_d = '0;
      end else begin
        if (w_wr_acc) wrcnt_d = wrcnt_q + 1'b1;
        unique case ({w_wr_acc, w_rd_acc})
          2'b10:   len_d = len_q + 1'b1;
          2'b01:   len_d = len_q - 1'b1;
          default: len_d = len_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wrcnt_q <= '0;
        len_q   <= '0;
      end else begin
        wrcnt_q <= wrcnt_d;
        len_q   <= len_d;
      end
    end

`ifdef FIFOCTRL_MCH_ERRFLAG_EN
    logic err_ovf_q;
    logic err_udf_q;

    // Sticky flags; a new offending request takes priority over err_clr_i.
    always_ff @(posedge clk) begin
      if (rst) begin
        err_ovf_q <= 1'b0;
        err_udf_q <= 1'b0;
      end else begin
        if (fifowr_i && w_wr_sel[c] && w_full[c]) begin
          err_ovf_q <= 1'b1;
        end else if (err_clr_i) begin
          err_ovf_q <= 1'b0;
        end
        if (fiford_i && w_rd_sel[c] && !w_nempty[c]) begin
          err_udf_q <= 1'b1;
        end else if (err_clr_i) begin
          err_udf_q <= 1'b0;
        end
      end
    end

    assign err_ovf_o[c] = err_ovf_q;
    assign err_udf_o[c] = err_udf_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_fifoctrl_mch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifoctrl_mch
// Description : Directed self-checking bench for fifoctrl_mch with
//               ADDRBIT=4, NCH=4, CHBIT=2. Inputs change 1 ns after the
//               rising edge; outputs are sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifoctrl_mch;

  logic        clk;
  logic        rst;
  logic        fifowr;
  logic [1:0]  wrch;
  logic        fiford;
  logic [1:0]  rdch;
  logic [3:0]  flush;
  logic [4:0]  afull_thr;
  logic [4:0]  aempty_thr;
  logic [3:0]  fifofull;
  logic [3:0]  notempty;
  logic [3:0]  almostfull;
  logic [3:0]  almostempty;
  logic [19:0] fifolen;
  logic        write;
  logic [5:0]  wraddr;
  logic        read;
  logic [5:0]  rdaddr;
`ifdef FIFOCTRL_MCH_ERRFLAG_EN
  logic        err_clr;
  logic [3:0]  err_ovf;
  logic [3:0]  err_udf;
`endif

  int checks = 0;
  int errors = 0;

  fifoctrl_mch #(
    .ADDRBIT (4),
    .NCH     (4),
    .CHBIT   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifowr_i      (fifowr),
    .wrch_i        (wrch),
    .fiford_i      (fiford),
    .rdch_i        (rdch),
    .flush_i       (flush),
    .afull_thr_i   (afull_thr),
    .aempty_thr_i  (aempty_thr),
`ifdef FIFOCTRL_MCH_ERRFLAG_EN
    .err_clr_i     (err_clr),
    .err_ovf_o     (err_ovf),
    .err_udf_o     (err_udf),
`endif
    .fifofull_o    (fifofull),
    .notempty_o    (notempty),
    .almostfull_o  (almostfull),
    .almostempty_o (almostempty),
    .fifolen_o     (fifolen),
    .write_o       (write),
    .wraddr_o      (wraddr),
    .read_o        (read),
    .rdaddr_o      (rdaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] lenof(input logic [19:0] v, input int c);
    return v[c*5 +: 5];
  endfunction

  initial begin
    rst        = 1'b1;
    fifowr     = 1'b0;
    wrch       = 2'd0;
    fiford     = 1'b0;
    rdch       = 2'd0;
    flush      = 4'b0;
    afull_thr  = 5'd0;
    aempty_thr = 5'd0;
`ifdef FIFOCTRL_MCH_ERRFLAG_EN
    err_clr    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // ---------------- reset state ----------------
    chk("rst_fifolen",     fifolen,     20'h0);
    chk("rst_notempty",    notempty,    4'h0);
    chk("rst_fifofull",    fifofull,    4'h0);
    chk("rst_almostempty", almostempty, 4'hF);
    chk("rst_afull_thr0",  almostfull,  4'hF);
    chk("rst_write",       write,       1'b0);
    chk("rst_read",        read,        1'b0);
    afull_thr = 5'd16;
    #1;
    chk("rst_afull_thr16", almostfull,  4'h0);

    // ---------------- fill ch1 ----------------
    for (int i = 0; i < 16; i++) begin
      fifowr = 1'b1;
      wrch   = 2'd1;
      #1;
      chk("fill1_write",  write,  1'b1);
      chk("fill1_wraddr", wraddr, 32'h10 + i);
      tick();
    end
    // 17th write, still requested
    #1;
    chk("full1_fifofull",   fifofull,   4'b0010);
    chk("full1_fifolen",    fifolen,    20'h00200);
    chk("full1_write_rej",  write,      1'b0);
    chk("full1_afull16",    almostfull, 4'b0010);
    afull_thr = 5'd17;
    #1;
    chk("full1_afull17",    almostfull, 4'b0000);
    aempty_thr = 5'd15;
    #1;
    chk("full1_aempty15",   almostempty, 4'b1101);
    aempty_thr = 5'd16;
    #1;
    chk("full1_aempty16",   almostempty, 4'b1111);
    afull_thr  = 5'd16;
    aempty_thr = 5'd0;
    tick();
    chk("full1_len_hold",   fifolen,    20'h00200);

    // read+write on full ch1: read wins, write rejected
    fifowr = 1'b1; wrch = 2'd1;
    fiford = 1'b1; rdch = 2'd1;
    #1;
    chk("full_rw_write",  write,  1'b0);
    chk("full_rw_read",   read,   1'b1);
    chk("full_rw_rdaddr", rdaddr, 6'h10);
    tick();
    fifowr = 1'b0;
    fiford = 1'b0;
    #1;
    chk("full_rw_len15", lenof(fifolen, 1), 5'd15);

    // ---------------- drain ch1 ----------------
    for (int i = 0; i < 15; i++) begin
      fiford = 1'b1;
      rdch   = 2'd1;
      #1;
      chk("drain1_read",   read,   1'b1);
      chk("drain1_rdaddr", rdaddr, 32'h11 + i);
      tick();
    end
    fiford = 1'b0;
    #1;
    chk("drain1_notempty", notempty, 4'h0);
    chk("drain1_fifolen",  fifolen,  20'h0);
    fiford = 1'b1;
    rdch   = 2'd1;
    #1;
    chk("empty1_read_rej", read, 1'b0);
    tick();
`ifdef FIFOCTRL_MCH_ERRFLAG_EN
    chk("err_udf", err_udf, 4'b0010);
    chk("err_ovf", err_ovf, 4'b0010);
`endif

    // read+write on empty ch1: write wins, read rejected
    fifowr = 1'b1; wrch = 2'd1;
    fiford = 1'b1; rdch = 2'd1;
    #1;
    chk("empty_rw_write",  write,  1'b1);
    chk("empty_rw_read",   read,   1'b0);
    chk("empty_rw_wraddr", wraddr, 6'h10);
    tick();
    fifowr = 1'b0;
    fiford = 1'b0;
    #1;
    chk("empty_rw_fifolen", fifolen, 20'h00020);
    fiford = 1'b1; rdch = 2'd1;
    #1;
    chk("empty_rw_rdaddr", rdaddr, 6'h10);
    tick();
    fiford = 1'b0;

    // ---------------- interleave ch0 / ch3 ----------------
    fifowr = 1'b1; wrch = 2'd3;
    #1;
    chk("pre3_wraddr0", wraddr, 6'h30);
    tick();
    #1;
    chk("pre3_wraddr1", wraddr, 6'h31);
    tick();
    fifowr = 1'b0;
    #1;
    chk("pre3_fifolen", fifolen, 20'h10000);
    for (int i = 0; i < 4; i++) begin
      fifowr = 1'b1;
      if (i % 2 == 0) begin
        wrch   = 2'd0;
        fiford = 1'b0;
        #1;
        chk("ilv_wraddr0", wraddr, 32'(i / 2));
      end else begin
        wrch   = 2'd3;
        fiford = 1'b1;
        rdch   = 2'd3;
        #1;
        chk("ilv_wraddr3", wraddr, 32'h32 + (i - 1) / 2);
        chk("ilv_rdaddr3", rdaddr, 32'h30 + (i - 1) / 2);
      end
      tick();
      chk("ilv_len3", lenof(fifolen, 3), 5'd2);
      chk("ilv_len0", lenof(fifolen, 0), 5'(i / 2 + 1));
    end
    // 20 cycles of simultaneous write+read on ch3; pointers wrap
    for (int k = 0; k < 20; k++) begin
      fifowr = 1'b1; wrch = 2'd3;
      fiford = 1'b1; rdch = 2'd3;
      #1;
      chk("wrap_write",  write,  1'b1);
      chk("wrap_read",   read,   1'b1);
      chk("wrap_wraddr", wraddr, 32'h30 | ((4 + k) % 16));
      chk("wrap_rdaddr", rdaddr, 32'h30 | ((2 + k) % 16));
      tick();
    end
    fifowr = 1'b0;
    fiford = 1'b0;
    #1;
    chk("wrap_len3", lenof(fifolen, 3), 5'd2);

    // ---------------- thresholds on ch2 ----------------
    afull_thr  = 5'd12;
    aempty_thr = 5'd2;
    #1;
    chk("thr_aempty_0", almostempty[2], 1'b1);
    chk("thr_afull_0",  almostfull[2],  1'b0);
    fifowr = 1'b1;
    wrch   = 2'd2;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 12) fifowr = 1'b0;
      chk("thr_aempty", almostempty[2], (n <= 2)  ? 1'b1 : 1'b0);
      chk("thr_afull",  almostfull[2],  (n >= 12) ? 1'b1 : 1'b0);
    end

    // ---------------- flush ch0 ----------------
    for (int i = 0; i < 3; i++) begin
      fifowr = 1'b1; wrch = 2'd0;
      #1;
      chk("pre0_wraddr", wraddr, 32'h02 + i);
      tick();
    end
    fifowr = 1'b0;
    #1;
    chk("pre0_len5", lenof(fifolen, 0), 5'd5);
    flush  = 4'b0001;
    fifowr = 1'b1; wrch = 2'd0;
    #1;
    chk("flush_write_rej", write, 1'b0);
    tick();
    flush  = 4'b0000;
    fifowr = 1'b0;
    rdch   = 2'd0;
    #1;
    chk("flush_len0",     lenof(fifolen, 0), 5'd0);
    chk("flush_notempty", notempty[0],       1'b0);
    chk("flush_wraddr",   wraddr,            6'h05);
    chk("flush_rdaddr",   rdaddr,            6'h05);
    chk("flush_others",   fifolen,           20'h13000);

    // ---------------- reset mid-traffic ----------------
    fifowr = 1'b1; wrch = 2'd2;
    rst    = 1'b1;
    #1;
    chk("rstmid_write", write, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_fifolen",  fifolen,  20'h0);
    chk("rstmid_notempty", notempty, 4'h0);
    chk("rstmid_wraddr",   wraddr,   6'h20);
    chk("rstmid_write2",   write,    1'b1);
    tick();
    fifowr = 1'b0;
    #1;
    chk("rstmid_len2", fifolen, 20'h00400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
